// File: rtl/trunc_issue_ctrl.sv
// Issue/capture stage for the gate-level truncation unit: accepts one request,
// drives the unit's operand pins for a settle window, then hands back the sampled result.
module trunc_issue_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InData,
    input  logic [4:0]  InAmt,
    input  logic        InDir,
    output logic [31:0] TrIn1,
    output logic [31:0] TrIn2,
    output logic        TrEnable,
    input  logic [31:0] TrOut,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutData,
    output logic        Busy,
    output logic [1:0]  DbgState
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // the producer holds valid and data stable until that edge, ready never depends on valid.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       load;
    logic       capture;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            TrIn1   <= 32'd0;
            TrIn2   <= 32'd0;
            OutData <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                TrIn1 <= InData;
                TrIn2 <= {InDir, 26'd0, InAmt};
            end
            // Only the last settle edge is sampled; the ripple is still moving before it.
            if (capture) begin
                OutData <= TrOut;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        capture   = 1'b0;
        InReady   = 1'b0;
        TrEnable  = 1'b0;
        OutValid  = 1'b0;
        Busy      = 1'b1;
        case (state)
            IDLE: begin
                InReady = ~Rst;
                Busy    = 1'b0;
                if (InValid) begin
                    load      = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                TrEnable = 1'b1;
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                // A new request is never taken here, even with OutReady; IDLE takes it next cycle.
                OutValid = 1'b1;
                if (OutReady) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign DbgState = state;

endmodule

// File: tb/tb_trunc_issue_ctrl.sv
// Bench for trunc_issue_ctrl: directed cases plus randomized traffic, checked by a
// queue-based scoreboard against a result model built from the truncation-unit stub.
module tb_trunc_issue_ctrl;
    localparam int SC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Main DUT (SETTLE_CYCLES = 2)
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic [4:0]  in_amt = 5'd0;
    logic        in_dir = 1'b0;
    logic [31:0] tr_in1, tr_in2, tr_out, out_data;
    logic        tr_en, out_valid, busy;
    logic        out_ready = 1'b0;
    logic [1:0]  dbg_state;
    logic        ready_force = 1'b1;
    logic        rand_ready = 1'b0;
    logic        prev_en = 1'b0;
    logic        glitch;

    always @(posedge clk) prev_en <= tr_en;
    assign glitch = tr_en & ~prev_en;
    assign tr_out = tr_en ? (glitch ? 32'hDEADBEEF : (tr_in1 ^ tr_in2)) : 32'h0;

    trunc_issue_ctrl #(.SETTLE_CYCLES(SC)) u_dut (
        .Clk(clk), .Rst(rst), .InValid(in_valid), .InReady(in_ready),
        .InData(in_data), .InAmt(in_amt), .InDir(in_dir),
        .TrIn1(tr_in1), .TrIn2(tr_in2), .TrEnable(tr_en), .TrOut(tr_out),
        .OutValid(out_valid), .OutReady(out_ready), .OutData(out_data),
        .Busy(busy), .DbgState(dbg_state)
    );

    // Second DUT (SETTLE_CYCLES = 1) for back-to-back throughput
    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [31:0] b_in_data = 32'd0;
    logic [4:0]  b_in_amt = 5'd0;
    logic        b_in_dir = 1'b0;
    logic [31:0] b_tr_in1, b_tr_in2, b_tr_out, b_out_data;
    logic        b_tr_en, b_out_valid, b_busy;
    logic [1:0]  b_dbg_state;

    assign b_tr_out = b_tr_en ? (b_tr_in1 ^ b_tr_in2) : 32'h0;

    trunc_issue_ctrl #(.SETTLE_CYCLES(1)) u_dut_b (
        .Clk(clk), .Rst(rst), .InValid(b_in_valid), .InReady(b_in_ready),
        .InData(b_in_data), .InAmt(b_in_amt), .InDir(b_in_dir),
        .TrIn1(b_tr_in1), .TrIn2(b_tr_in2), .TrEnable(b_tr_en), .TrOut(b_tr_out),
        .OutValid(b_out_valid), .OutReady(1'b1), .OutData(b_out_data),
        .Busy(b_busy), .DbgState(b_dbg_state)
    );

    logic [31:0] exp_q[$];
    int          acc_q[$];
    logic [31:0] exp_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a, input logic dir);
        logic [31:0] in2;
        in2 = 32'(a);
        in2[31] = dir;
        return d ^ in2;
    endfunction

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Monitor for the main DUT
    logic        mon_en = 1'b0;
    logic        ov_prev = 1'b0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_data = 32'd0;
    logic        acc_prev = 1'b1;
    logic [31:0] in1_prev = 32'd0;
    logic [31:0] in2_prev = 32'd0;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            ov_prev = 1'b0;
            hold_pend = 1'b0;
            acc_prev = 1'b1;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, hold_data);
            end
            if (!acc_prev) begin
                check("trin1_stable", tr_in1, in1_prev);
                check("trin2_stable", tr_in2, in2_prev);
            end
            if (out_valid && !ov_prev) begin
                if (acc_q.size() == 0) check("spurious_valid", 32'(out_valid), 32'd0);
                else check("latency", 32'(cyc), 32'(acc_q.pop_front() + SC));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", 32'(out_valid), 32'd0);
                else check("result", out_data, exp_q.pop_front());
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            ov_prev   = out_valid;
            acc_prev  = in_valid && in_ready;
            in1_prev  = tr_in1;
            in2_prev  = tr_in2;
        end
    end

    // Monitor for the back-to-back DUT (OutReady tied high)
    always @(negedge clk) begin
        if (!rst && b_out_valid) begin
            if (exp_b_q.size() == 0) check("b_unexpected_result", 32'(b_out_valid), 32'd0);
            else check("b_result", b_out_data, exp_b_q.pop_front());
        end
    end

    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic dir, input bit push);
        int n;
        in_valid = 1'b1;
        in_data = d;
        in_amt = a;
        in_dir = dir;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = $urandom;
        in_amt = 5'($urandom_range(0, 31));
        in_dir = 1'($urandom_range(0, 1));
        if (push) begin
            exp_q.push_back(model(d, a, dir));
            acc_q.push_back(cyc);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) check("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r_cyc;
        int n;
        int last_acc;
        logic [31:0] d;

        // 1. Reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_tr_en", 32'(tr_en), 32'd0);
            check("rst_tr_in1", tr_in1, 32'd0);
            check("rst_tr_in2", tr_in2, 32'd0);
            check("rst_out_data", out_data, 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        check("state_after_rst", 32'(dbg_state), 32'd0);
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // 2. Basic request
        ready_force = 1'b1;
        send(32'hFFFF0000, 5'd8, 1'b1, 1'b1);
        check("basic_tr_in1", tr_in1, 32'hFFFF0000);
        check("basic_tr_in2", tr_in2, 32'h80000008);
        check("basic_tr_en", 32'(tr_en), 32'd1);
        check("basic_busy", 32'(busy), 32'd1);
        wait_idle();
        check("basic_out_data", out_data, 32'h7FFF0008);

        // 3. Backpressure with a second request waiting
        ready_force = 1'b0;
        send(32'hA5A51234, 5'd3, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_data = 32'h0F0F0F0F;
        in_amt = 5'd31;
        in_dir = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        ready_force = 1'b1;
        @(negedge clk);
        check("done_no_accept", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        r_cyc = cyc;
        @(negedge clk);
        check("bp_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(model(32'h0F0F0F0F, 5'd31, 1'b1));
        acc_q.push_back(cyc);
        check("bp_accept_cycle", 32'(cyc), 32'(r_cyc + 1));
        check("bp_second_tr_in1", tr_in1, 32'h0F0F0F0F);
        wait_idle();

        // 4. Settle sampling (stub glitches on the first SETTLE cycle); InAmt=0 passes through
        send(32'h12345678, 5'd0, 1'b0, 1'b1);
        wait_idle();
        check("glitch_ignored", out_data, 32'h12345678);
        send(32'h00000000, 5'd0, 1'b1, 1'b1);
        wait_idle();
        check("amt0_dir1", out_data, 32'h80000000);

        // 5. Reset mid-SETTLE discards the request
        send(32'hCAFEBABE, 5'd4, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_out_valid", 32'(out_valid), 32'd0);
            check("mid_rst_out_data", out_data, 32'd0);
            check("mid_rst_state", 32'(dbg_state), 32'd0);
            check("mid_rst_busy", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;

        // Randomized traffic with random consumer backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
            send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b1);
        end
        rand_ready = 1'b0;
        ready_force = 1'b1;
        wait_idle();

        // 6. Back-to-back on the SETTLE_CYCLES=1 instance
        last_acc = 0;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            b_in_valid = 1'b1;
            b_in_data = d;
            b_in_amt = 5'(i * 7 + 1);
            b_in_dir = 1'(i);
            n = 0;
            @(negedge clk);
            while (!b_in_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (n >= 50) check("b_accept_timeout", 32'(b_in_ready), 32'd1);
            @(posedge clk);
            #1;
            exp_b_q.push_back(model(d, 5'(i * 7 + 1), 1'(i)));
            if (i > 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd3);
            last_acc = cyc;
        end
        b_in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("b_drain", 32'(exp_b_q.size()), 32'd0);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
